// File: rtl/inst_encoder.sv
// inst_encoder: packs decoded RV32I fields into 32-bit instruction words and
// writes them to consecutive instruction-memory addresses.
//   clk, rst_n                  clock, async active-low reset
//   in_valid/in_ready           field-bundle handshake
//   in_fmt, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm   decoded fields
//   in_flush                    restart program (address, count, flags)
//   imem_we/addr/wdata/ack      acknowledged instruction-memory write port
//   words_written, full         successful writes since reset/flush
//   err_imm, err_fmt            sticky drop flags
module inst_encoder #(
  parameter int unsigned MEM_ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_fmt,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [2:0]            in_funct3,
  input  logic [6:0]            in_funct7,
  input  logic [31:0]           in_imm,
  input  logic                  in_flush,
  output logic                  imem_we,
  output logic [MEM_ADDR_W-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  input  logic                  imem_ack,
  output logic [MEM_ADDR_W:0]   words_written,
  output logic                  full,
  output logic                  err_imm,
  output logic                  err_fmt
);

  typedef enum logic [1:0] {S_IDLE, S_ENC, S_WRITE} state_e;
  typedef enum logic [2:0] {
    FMT_I, FMT_R, FMT_B, FMT_S, FMT_LOAD, FMT_LUI, FMT_AUIPC, FMT_RSVD
  } fmt_e;

  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  state_e                state_q, state_d;
  fmt_e                  fmt_q, fmt_d;
  logic [4:0]            rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [2:0]            f3_q, f3_d;
  logic [6:0]            f7_q, f7_d;
  logic [31:0]           imm_q, imm_d;
  logic [MEM_ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [MEM_ADDR_W:0]   words_q, words_d;
  logic                  err_imm_q, err_imm_d, err_fmt_q, err_fmt_d;
  logic                  flush_pend_q, flush_pend_d;

  logic [31:0] enc_word;
  logic        imm_bad, fmt_bad;
  logic        sext12_ok, sext13_ok;

  // Words written can never exceed 2^MEM_ADDR_W, so the top bit alone marks full.
  assign full          = words_q[MEM_ADDR_W];
  assign in_ready      = (state_q == S_IDLE) && !full && !flush_pend_q;
  assign imem_we       = (state_q == S_WRITE);
  assign imem_addr     = addr_q;
  assign imem_wdata    = wdata_q;
  assign words_written = words_q;
  assign err_imm       = err_imm_q;
  assign err_fmt       = err_fmt_q;

  assign sext12_ok = (&imm_q[31:11]) || (~|imm_q[31:11]);
  assign sext13_ok = (&imm_q[31:12]) || (~|imm_q[31:12]);

  always_comb begin
    enc_word = '0;
    imm_bad  = 1'b0;
    fmt_bad  = 1'b0;
    case (fmt_q)
      FMT_I: begin
        if (f3_q == 3'b001 || f3_q == 3'b101) begin
          enc_word = {f7_q, imm_q[4:0], rs1_q, f3_q, rd_q, OP_I};
          imm_bad  = |imm_q[31:5];
        end else begin
          enc_word = {imm_q[11:0], rs1_q, f3_q, rd_q, OP_I};
          imm_bad  = !sext12_ok;
        end
      end
      FMT_LOAD: begin
        enc_word = {imm_q[11:0], rs1_q, f3_q, rd_q, OP_LOAD};
        imm_bad  = !sext12_ok;
      end
      FMT_R: enc_word = {f7_q, rs2_q, rs1_q, f3_q, rd_q, OP_R};
      FMT_S: begin
        enc_word = {imm_q[11:5], rs2_q, rs1_q, f3_q, imm_q[4:0], OP_S};
        imm_bad  = !sext12_ok;
      end
      FMT_B: begin
        enc_word = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, f3_q, imm_q[4:1], imm_q[11], OP_B};
        imm_bad  = !sext13_ok || imm_q[0];
      end
      FMT_LUI: begin
        enc_word = {imm_q[31:12], rd_q, OP_LUI};
        imm_bad  = |imm_q[11:0];
      end
      FMT_AUIPC: begin
        enc_word = {imm_q[31:12], rd_q, OP_AUIPC};
        imm_bad  = |imm_q[11:0];
      end
      default: fmt_bad = 1'b1;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    fmt_d        = fmt_q;
    rd_d         = rd_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    f3_d         = f3_q;
    f7_d         = f7_q;
    imm_d        = imm_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    words_d      = words_q;
    err_imm_d    = err_imm_q;
    err_fmt_d    = err_fmt_q;
    flush_pend_d = flush_pend_q;
    case (state_q)
      S_IDLE: begin
        // A pending flush and a fresh flush are applied identically; both win over in_valid.
        if (flush_pend_q || in_flush) begin
          addr_d       = '0;
          words_d      = '0;
          err_imm_d    = 1'b0;
          err_fmt_d    = 1'b0;
          flush_pend_d = 1'b0;
        end else if (in_valid && in_ready) begin
          fmt_d   = fmt_e'(in_fmt);
          rd_d    = in_rd;
          rs1_d   = in_rs1;
          rs2_d   = in_rs2;
          f3_d    = in_funct3;
          f7_d    = in_funct7;
          imm_d   = in_imm;
          state_d = S_ENC;
        end
      end
      S_ENC: begin
        state_d = S_IDLE;
        if (in_flush) begin
          addr_d    = '0;
          words_d   = '0;
          err_imm_d = 1'b0;
          err_fmt_d = 1'b0;
        end else if (fmt_bad) begin
          err_fmt_d = 1'b1;
        end else if (imm_bad) begin
          err_imm_d = 1'b1;
        end else begin
          wdata_d = enc_word;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (in_flush) flush_pend_d = 1'b1;
        if (imem_ack) begin
          addr_d  = addr_q + 1'b1;
          words_d = words_q + 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      fmt_q        <= FMT_I;
      rd_q         <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      f3_q         <= '0;
      f7_q         <= '0;
      imm_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      words_q      <= '0;
      err_imm_q    <= 1'b0;
      err_fmt_q    <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fmt_q        <= fmt_d;
      rd_q         <= rd_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      f3_q         <= f3_d;
      f7_q         <= f7_d;
      imm_q        <= imm_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      words_q      <= words_d;
      err_imm_q    <= err_imm_d;
      err_fmt_q    <= err_fmt_d;
      flush_pend_q <= flush_pend_d;
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder with a 4-word memory (MEM_ADDR_W=2).
module tb_inst_encoder;

  localparam int unsigned AW    = 2;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_fmt = '0;
  logic [4:0]    in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]    in_funct3 = '0;
  logic [6:0]    in_funct7 = '0;
  logic [31:0]   in_imm = '0;
  logic          in_flush = 1'b0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          imem_ack = 1'b0;
  logic [AW:0]   words_written;
  logic          full, err_imm, err_fmt;

  inst_encoder #(.MEM_ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .in_flush(in_flush), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .imem_ack(imem_ack), .words_written(words_written),
    .full(full), .err_imm(err_imm), .err_fmt(err_fmt)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  int unsigned m_addr = 0;
  int unsigned m_words = 0;
  bit          m_err_imm = 0;
  bit          m_err_fmt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Encoding straight from the ISA field layout, using integer arithmetic.
  function automatic logic [31:0] ref_word(
    input int unsigned fmt, input int unsigned rd, input int unsigned rs1,
    input int unsigned rs2, input int unsigned f3, input int unsigned f7,
    input logic [31:0] imm, output bit bad_imm, output bit bad_fmt);
    int          si;
    int unsigned u;
    int unsigned w;
    si = $signed(imm);
    u  = imm;
    bad_imm = 0;
    bad_fmt = 0;
    w = 0;
    case (fmt)
      0: begin
        if (f3 == 1 || f3 == 5) begin
          bad_imm = (u > 31);
          w = (f7 << 25) + ((u % 32) << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + 'h13;
        end else begin
          bad_imm = (si < -2048) || (si > 2047);
          w = ((u % 4096) << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + 'h13;
        end
      end
      1: w = (f7 << 25) + (rs2 << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + 'h33;
      2: begin
        bad_imm = (si < -4096) || (si > 4095) || (u % 2 != 0);
        w = (((u / 4096) % 2) << 31) + (((u / 32) % 64) << 25) + (rs2 << 20) + (rs1 << 15)
          + (f3 << 12) + (((u / 2) % 16) << 8) + (((u / 2048) % 2) << 7) + 'h63;
      end
      3: begin
        bad_imm = (si < -2048) || (si > 2047);
        w = (((u / 32) % 128) << 25) + (rs2 << 20) + (rs1 << 15) + (f3 << 12)
          + ((u % 32) << 7) + 'h23;
      end
      4: begin
        bad_imm = (si < -2048) || (si > 2047);
        w = ((u % 4096) << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + 'h03;
      end
      5, 6: begin
        bad_imm = (u % 4096 != 0);
        w = (u - (u % 4096)) + (rd << 7) + ((fmt == 5) ? 'h37 : 'h17);
      end
      default: bad_fmt = 1;
    endcase
    return w;
  endfunction

  task automatic do_flush(input string tag);
    in_flush = 1'b1;
    @(negedge clk);
    in_flush = 1'b0;
    m_addr = 0; m_words = 0; m_err_imm = 0; m_err_fmt = 0;
    check({tag, "_addr"},  32'(imem_addr), 0);
    check({tag, "_words"}, 32'(words_written), 0);
    check({tag, "_full"},  32'(full), 0);
    check({tag, "_errs"},  {30'd0, err_imm, err_fmt}, 0);
    check({tag, "_ready"}, 32'(in_ready), 1);
  endtask

  // One full transaction, called at a negedge with the DUT in IDLE.
  task automatic send(input string tag, input int unsigned fmt, input int unsigned rd,
                      input int unsigned rs1, input int unsigned rs2, input int unsigned f3,
                      input int unsigned f7, input logic [31:0] imm, input int unsigned delay);
    logic [31:0] w;
    bit bi, bf;
    w = ref_word(fmt, rd, rs1, rs2, f3, f7, imm, bi, bf);
    check({tag, "_ready_in"}, 32'(in_ready), 32'(m_words < DEPTH));
    in_valid = 1'b1; in_fmt = 3'(fmt); in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2);
    in_funct3 = 3'(f3); in_funct7 = 7'(f7); in_imm = imm;
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_enc_we"}, {31'd0, imem_we}, 0);
    check({tag, "_enc_rdy"}, 32'(in_ready), 0);
    @(negedge clk);
    if (bf || bi) begin
      if (bf) m_err_fmt = 1; else m_err_imm = 1;
      check({tag, "_drop_we"}, 32'(imem_we), 0);
      check({tag, "_drop_err"}, {30'd0, err_imm, err_fmt}, {30'd0, m_err_imm, m_err_fmt});
      check({tag, "_drop_rdy"}, 32'(in_ready), 1);
      check({tag, "_drop_addr"}, 32'(imem_addr), m_addr);
    end else begin
      check({tag, "_we"}, 32'(imem_we), 1);
      check({tag, "_addr"}, 32'(imem_addr), m_addr);
      check({tag, "_data"}, imem_wdata, w);
      for (int i = 0; i < int'(delay); i++) begin
        @(negedge clk);
        check({tag, "_hold_we"}, 32'(imem_we), 1);
        check({tag, "_hold_addr"}, 32'(imem_addr), m_addr);
        check({tag, "_hold_data"}, imem_wdata, w);
      end
      imem_ack = 1'b1;
      @(negedge clk);
      imem_ack = 1'b0;
      m_addr = (m_addr + 1) % DEPTH;
      m_words++;
      check({tag, "_post_we"}, 32'(imem_we), 0);
      check({tag, "_post_addr"}, 32'(imem_addr), m_addr);
      check({tag, "_post_words"}, 32'(words_written), m_words);
      check({tag, "_post_full"}, 32'(full), 32'(m_words == DEPTH));
      check({tag, "_post_rdy"}, 32'(in_ready), 32'(m_words < DEPTH));
    end
  endtask

  initial begin
    logic [31:0] rimm;
    int unsigned fmt, f3, mode;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(in_ready), 1);
    check("rst_we", 32'(imem_we), 0);
    check("rst_addr", 32'(imem_addr), 0);
    check("rst_wdata", imem_wdata, 0);
    check("rst_words", 32'(words_written), 0);
    check("rst_flags", {29'd0, full, err_imm, err_fmt}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // addi x1,x0,5
    send("addi", 0, 1, 0, 0, 0, 0, 32'd5, 0);
    check("addi_lit", imem_wdata, 32'h0050_0093);
    do_flush("fl0");

    // srai x5,x6,3 then beq x1,x2,+8
    send("srai", 0, 5, 6, 0, 5, 7'h20, 32'd3, 0);
    check("srai_lit", imem_wdata, 32'h4033_5293);
    send("beq", 2, 0, 1, 2, 0, 0, 32'd8, 0);
    check("beq_lit", imem_wdata, 32'h0020_8463);

    // lui with 5 cycles of back-pressure
    send("lui", 5, 1, 0, 0, 0, 0, 32'h1234_5000, 5);
    check("lui_lit", imem_wdata, 32'h1234_50B7);

    // Dropped words
    send("bad_addi", 0, 1, 0, 0, 0, 0, 32'd2048, 0);
    send("bad_fmt", 7, 1, 2, 3, 0, 0, 32'd0, 0);
    send("bad_b", 2, 0, 1, 2, 0, 0, 32'd7, 0);
    check("bad_words", 32'(words_written), 3);
    do_flush("fl1");

    // Fill the memory
    for (int i = 0; i < int'(DEPTH); i++) send("fill", 1, i, i + 1, i + 2, 0, 0, 32'd0, 0);
    check("full_flag", 32'(full), 1);
    check("full_ready", 32'(in_ready), 0);
    check("full_words", 32'(words_written), DEPTH);
    do_flush("fl2");

    // Flush during WRITE: word completes, flush lands one edge after ack
    send("pre", 1, 3, 4, 5, 0, 0, 32'd0, 0);
    in_valid = 1'b1; in_fmt = 3'd3; in_rs1 = 5'd2; in_rs2 = 5'd9; in_funct3 = 3'd2; in_imm = 32'hFFFF_FFF0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("fw_we", 32'(imem_we), 1);
    in_flush = 1'b1;
    @(negedge clk);
    in_flush = 1'b0;
    check("fw_still_we", 32'(imem_we), 1);
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    check("fw_ack_addr", 32'(imem_addr), 2);
    check("fw_ack_words", 32'(words_written), 2);
    check("fw_pend_rdy", 32'(in_ready), 0);
    @(negedge clk);
    check("fw_clr_addr", 32'(imem_addr), 0);
    check("fw_clr_words", 32'(words_written), 0);
    check("fw_clr_rdy", 32'(in_ready), 1);
    m_addr = 0; m_words = 0; m_err_imm = 0; m_err_fmt = 0;

    // Flush with in_valid in IDLE: bundle not taken
    in_flush = 1'b1; in_valid = 1'b1; in_fmt = 3'd1;
    @(negedge clk);
    in_flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("fv_we", 32'(imem_we), 0);
    check("fv_words", 32'(words_written), 0);
    check("fv_ready", 32'(in_ready), 1);

    // Randomized transactions
    for (int n = 0; n < 60; n++) begin
      if (m_words == DEPTH) do_flush("rfl");
      fmt  = $urandom_range(0, 7);
      f3   = $urandom_range(0, 7);
      mode = $urandom_range(0, 3);
      rimm = $urandom;
      if (mode != 0) begin
        case (fmt)
          0: if (f3 == 1 || f3 == 5) rimm = rimm % 32;
             else rimm = (rimm % 4096) - 2048;
          2: rimm = ((rimm % 4096) - 2048) * 2;
          3, 4: rimm = (rimm % 4096) - 2048;
          5, 6: rimm = rimm - (rimm % 4096);
          default: ;
        endcase
      end
      send("rnd", fmt, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
           f3, $urandom_range(0, 127), rimm, $urandom_range(0, 3));
    end

    // Reset in the middle of a write drops imem_we without a clock edge
    if (m_words == DEPTH) do_flush("rfl2");
    in_valid = 1'b1; in_fmt = 3'd1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("rw_we", 32'(imem_we), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rw_rst_we", 32'(imem_we), 0);
    check("rw_rst_addr", 32'(imem_addr), 0);
    check("rw_rst_words", 32'(words_written), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rw_ready", 32'(in_ready), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
